// File: rtl/mem_arbiter.sv
// Two-port (instruction/data cache) arbiter in front of a line-wide backing memory.
// One transaction at a time, fixed latency, round-robin on simultaneous petitions.
module mem_arbiter #(
    parameter int cache_line_width = 256,
    parameter int addr_width       = 16,
    parameter int num_lines        = 64,
    parameter int mem_latency      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        petitionICache,
    input  logic [addr_width-1:0]       addrICache,
    output logic                        serviceReadyICache,
    output logic [cache_line_width-1:0] dataToICache,
    input  logic                        petitionDCache,
    input  logic                        writeDCache,
    input  logic [addr_width-1:0]       addrDCache,
    input  logic [cache_line_width-1:0] dataFromDCache,
    output logic                        serviceReadyDCache,
    output logic [cache_line_width-1:0] dataToDCache
);
    localparam int IdxW = $clog2(num_lines);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {REQ_I, REQ_D} req_t;

    state_t                      state_q;
    logic [7:0]                  cnt_q;
    req_t                        gnt_q;
    req_t                        last_q;
    logic                        wr_q;
    logic [IdxW-1:0]             idx_q;
    logic [cache_line_width-1:0] wdata_q;
    logic                        srI_q;
    logic                        srD_q;
    logic [cache_line_width-1:0] dI_q;
    logic [cache_line_width-1:0] dD_q;
    logic [cache_line_width-1:0] mem [num_lines];

    req_t gnt_d;
    logic commit_wr;

    always_comb begin
        gnt_d = REQ_D;
        if (petitionICache && petitionDCache)
            gnt_d = (last_q == REQ_D) ? REQ_I : REQ_D;
        else if (petitionICache)
            gnt_d = REQ_I;
    end

    // Memory write happens only on the completing edge and never under reset,
    // so a reset mid-transaction leaves the array untouched.
    assign commit_wr = reset && (state_q == BUSY) && (cnt_q == '0) && wr_q;

    always_ff @(posedge clk) begin
        if (commit_wr)
            mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            srI_q   <= 1'b0;
            srD_q   <= 1'b0;
            dI_q    <= '0;
            dD_q    <= '0;
            last_q  <= REQ_D;
        end else begin
            srI_q <= 1'b0;
            srD_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (petitionICache || petitionDCache) begin
                        gnt_q   <= gnt_d;
                        idx_q   <= (gnt_d == REQ_I) ? addrICache[IdxW+3:4] : addrDCache[IdxW+3:4];
                        wr_q    <= (gnt_d == REQ_D) && writeDCache;
                        wdata_q <= dataFromDCache;
                        cnt_q   <= 8'(mem_latency - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (gnt_q == REQ_I) begin
                            srI_q <= 1'b1;
                            dI_q  <= mem[idx_q];
                        end else begin
                            srD_q <= 1'b1;
                            dD_q  <= wr_q ? wdata_q : mem[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serviceReadyICache = srI_q;
    assign serviceReadyDCache = srD_q;
    assign dataToICache       = dI_q;
    assign dataToDCache       = dD_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle,
// plus literal expectations for latency, arbitration order and returned lines.
module tb_mem_arbiter;
    localparam int W   = 256;
    localparam int LAT = 5;
    localparam int NL  = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          petI = 1'b0, petD = 1'b0, wrD = 1'b0;
    logic [15:0]   addrI = '0, addrD = '0;
    logic [W-1:0]  dFrom = '0;
    logic          srI, srD;
    logic [W-1:0]  dToI, dToD;

    int tests = 0;
    int failed = 0;
    bit checking = 1'b0;

    mem_arbiter #(.cache_line_width(W), .addr_width(16), .num_lines(NL), .mem_latency(LAT)) dut (
        .clk(clk), .reset(reset),
        .petitionICache(petI), .addrICache(addrI),
        .serviceReadyICache(srI), .dataToICache(dToI),
        .petitionDCache(petD), .writeDCache(wrD), .addrDCache(addrD),
        .dataFromDCache(dFrom),
        .serviceReadyDCache(srD), .dataToDCache(dToD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int k);
        logic [15:0] w;
        w = 16'h1100 + 16'(k);
        return {16{w}};
    endfunction

    // Transaction model: a petition seen while the port is free completes
    // LAT edges later; the port is free again two edges after that.
    logic [W-1:0] m_mem [NL];
    logic [W-1:0] exp_di = '0, exp_dd = '0;
    int  edge_n = 0, next_free = 0, done_edge = -1, p_idx = 0;
    bit  p_i = 1'b0, p_w = 1'b0, last_d = 1'b1;
    logic [W-1:0] p_data = '0;

    always @(posedge clk) begin
        if (!reset) begin
            done_edge = -1;
            next_free = edge_n + 1;
            exp_di = '0;
            exp_dd = '0;
            last_d = 1'b1;
        end else begin
            if (edge_n == done_edge) begin
                if (p_w) begin
                    m_mem[p_idx] = p_data;
                    exp_dd = p_data;
                end else if (p_i) exp_di = m_mem[p_idx];
                else exp_dd = m_mem[p_idx];
                last_d = !p_i;
            end
            if (edge_n >= next_free && (petI || petD)) begin
                p_i = petI && (!petD || last_d);
                p_w = !p_i && wrD;
                p_idx = ((p_i ? int'(addrI) : int'(addrD)) / 16) % NL;
                p_data = dFrom;
                done_edge = edge_n + LAT;
                next_free = edge_n + LAT + 2;
            end
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("srI", W'(srI), W'((done_edge == edge_n - 1) && p_i));
            chk("srD", W'(srD), W'((done_edge == edge_n - 1) && !p_i));
            chk("dataToI", dToI, exp_di);
            chk("dataToD", dToD, exp_dd);
        end
    end

    // Petition held for exactly the sampling cycle, then dropped with the
    // address scrambled; returns the number of negedges until the pulse.
    task automatic do_req(input bit is_i, input bit wr, input logic [15:0] a,
                          input logic [W-1:0] d, output int seen);
        @(negedge clk);
        if (is_i) begin petI = 1'b1; addrI = a; end
        else begin petD = 1'b1; addrD = a; wrD = wr; dFrom = d; end
        seen = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                petI = 1'b0; petD = 1'b0; wrD = 1'b0;
                addrI = 16'hFFFF; addrD = 16'hFFFF; dFrom = ~d;
            end
            if (is_i ? srI : srD) begin
                seen = n;
                break;
            end
        end
        if (seen < 0) begin
            tests++;
            failed++;
            $display("FAIL req_timeout got=none exp=pulse");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    int seen, seenI, seenD, overlap, pulses;

    initial begin
        for (int i = 0; i < NL; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checking = 1'b1;
        chk("rst_srI", W'(srI), '0);
        chk("rst_srD", W'(srD), '0);
        chk("rst_dI", dToI, '0);
        chk("rst_dD", dToD, '0);
        reset = 1'b1;

        for (int k = 0; k < 4; k++) begin
            do_req(1'b0, 1'b1, 16'(k * 16 + 3), mk(k), seen);
            chk("preload_dD", dToD, mk(k));
        end

        do_req(1'b1, 1'b0, 16'h0023, '0, seen);
        chk("iread_lat", W'(seen), W'(6));
        chk("iread_data", dToI, mk(2));

        // Simultaneous petitions right after reset
        do_reset();
        @(negedge clk);
        petI = 1'b1; petD = 1'b1; wrD = 1'b0;
        addrI = 16'h0013; addrD = 16'h0033;
        seenI = -1; seenD = -1; overlap = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (srI && srD) overlap++;
            if (srI && seenI < 0) begin seenI = n; petI = 1'b0; end
            if (srD && seenD < 0) begin seenD = n; petD = 1'b0; end
            if (seenI >= 0 && seenD >= 0) break;
        end
        chk("tie_i_lat", W'(seenI), W'(6));
        chk("tie_d_lat", W'(seenD), W'(13));
        chk("tie_overlap", W'(overlap), '0);
        chk("tie_dI", dToI, mk(1));
        chk("tie_dD", dToD, mk(3));

        do_req(1'b0, 1'b1, 16'h0050, {16{16'hBEEF}}, seen);
        chk("wr_lat", W'(seen), W'(6));
        chk("wr_echo", dToD, {16{16'hBEEF}});
        do_req(1'b1, 1'b0, 16'h0057, '0, seen);
        chk("wr_rd_data", dToI, {16{16'hBEEF}});

        do_req(1'b1, 1'b0, 16'h0403, '0, seen);
        chk("wrap_data", dToI, mk(0));

        do_req(1'b0, 1'b0, 16'h003F, '0, seen);
        chk("drop_dread", dToD, mk(3));

        // Reset during the third BUSY cycle of a write to line 1
        @(negedge clk);
        petD = 1'b1; wrD = 1'b1; addrD = 16'h0010; dFrom = {16{16'hDEAD}};
        @(negedge clk);
        petD = 1'b0; wrD = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (srI || srD) pulses++;
        end
        chk("abort_pulses", W'(pulses), '0);
        chk("abort_dD", dToD, '0);
        do_req(1'b1, 1'b0, 16'h0019, '0, seen);
        chk("abort_idle_lat", W'(seen), W'(6));
        chk("abort_mem", dToI, mk(1));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
endmodule
